// File: rtl/dma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dma_mem_responder
// Brief   : Memory-side responder for DMA word transfers. Accepts one
//           read/write request at a time, inserts WAIT_CYCLES wait states,
//           accesses a local word-addressed SRAM window at BASE_ADDR and
//           returns a response with an error flag for misaligned or
//           out-of-window accesses.
// Revision: 1.0 - initial release
// ============================================================================
module dma_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic [15:0] xfer_count
);

    localparam int          c_aw     = $clog2(DEPTH);
    localparam logic [32:0] c_win_lo = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_win_hi = c_win_lo + 33'(4 * DEPTH);
    localparam logic [3:0]  c_wait_n = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_wait   = 2'd1;
    localparam logic [1:0] c_access = 2'd2;
    localparam logic [1:0] c_resp   = 2'd3;

    logic [1:0]  state_q,      state_d;
    logic [3:0]  wait_cnt_q,   wait_cnt_d;
    logic        req_ready_q,  req_ready_d;
    logic        busy_q,       busy_d;
    logic        rsp_valid_q,  rsp_valid_d;
    logic [31:0] rsp_rdata_q,  rsp_rdata_d;
    logic        rsp_error_q,  rsp_error_d;
    logic [15:0] xfer_count_q, xfer_count_d;
    logic        lat_write_q,  lat_write_d;
    logic [31:0] lat_addr_q,   lat_addr_d;
    logic [31:0] lat_wdata_q,  lat_wdata_d;
    logic [3:0]  lat_wstrb_q,  lat_wstrb_d;
    logic        acc_err_q,    acc_err_d;

    logic [31:0] mem [DEPTH];
    logic [31:0] sram_rdata;

    logic             w_accept;
    logic             w_in_range;
    logic             w_err;
    logic [31:0]      w_off;
    logic [c_aw-1:0]  w_idx;
    logic             w_unused_off;

    assign w_accept     = req_valid && req_ready_q;
    // 33-bit compare so a window ending at the top of the address space cannot wrap
    assign w_in_range   = ({1'b0, lat_addr_q} >= c_win_lo) && ({1'b0, lat_addr_q} < c_win_hi);
    assign w_err        = !w_in_range || (lat_addr_q[1:0] != 2'b00);
    assign w_off        = lat_addr_q - BASE_ADDR;
    assign w_idx        = w_off[c_aw+1:2];
    assign w_unused_off = ^{w_off[31:c_aw+2], w_off[1:0]};

    // State and control/response registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= c_idle;
            wait_cnt_q   <= 4'd0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_error_q  <= 1'b0;
            xfer_count_q <= 16'd0;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= 32'd0;
            lat_wdata_q  <= 32'd0;
            lat_wstrb_q  <= 4'd0;
            acc_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
            xfer_count_q <= xfer_count_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_wstrb_q  <= lat_wstrb_d;
            acc_err_q    <= acc_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:   if (w_accept) state_d = (WAIT_CYCLES > 0) ? c_wait : c_access;
            c_wait:   if (wait_cnt_q <= 4'd1) state_d = c_access;
            c_access: state_d = c_resp;
            c_resp:   if (rsp_valid_q && rsp_ready) state_d = c_idle;
            default:  state_d = c_idle;
        endcase
    end

    // Output and datapath register updates per state
    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_error_d  = rsp_error_q;
        xfer_count_d = xfer_count_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        lat_wstrb_d  = lat_wstrb_q;
        acc_err_d    = acc_err_q;
        case (state_q)
            c_idle: begin
                req_ready_d = 1'b1;
                if (w_accept) begin
                    lat_write_d = req_write;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    lat_wstrb_d = req_wstrb;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    wait_cnt_d  = c_wait_n;
                end
            end
            c_wait: wait_cnt_d = wait_cnt_q - 4'd1;
            c_access: acc_err_d = w_err;
            c_resp: begin
                // The SRAM read port is registered, so the response is formed
                // on the first RESP cycle and then held until taken.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = acc_err_q;
                    rsp_rdata_d = (lat_write_q || acc_err_q) ? 32'd0 : sram_rdata;
                end else if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    rsp_error_d  = 1'b0;
                    rsp_rdata_d  = 32'd0;
                    busy_d       = 1'b0;
                    xfer_count_d = xfer_count_q + 16'd1;
                    req_ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // SRAM array: byte-lane writes and registered read, only during ACCESS
    always_ff @(posedge clk) begin
        if (state_q == c_access) begin
            sram_rdata <= mem[w_idx];
            if (lat_write_q && !w_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (lat_wstrb_q[i]) mem[w_idx][8*i +: 8] <= lat_wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_error  = rsp_error_q;
    assign xfer_count = xfer_count_q;

endmodule
`default_nettype wire
